fft_bitrev_reorder: RTL and testbench
=====================================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output reorder stage that sits directly downstream of the DIT FFT (dit). It takes the
//  FFT's bit-reversed output stream and re-emits each N-point frame in natural order.
//  Double-buffered (ping-pong), so a frame is written while the previous one streams out.
//  Carries the per-sample tag (m) and the frame-start flag through, and flags misalignment.
// PARAMETERS
//  N        16  points per frame; must be a power of 2, N >= 4
//  NLOG2     4  log2(N)
//  X_WDTH   16  width of each real/imag part; a sample is X_WDTH*2 bits
//  M_WDTH    8  width of the per-sample tag carried with the data
// PORTS
//  clk        in   1          single clock; every register is clocked on its rising edge
//  rst        in   1          synchronous, active-high reset
//  in_data    in   X_WDTH*2   FFT output sample {re,im}, bit-reversed order within frame
//  in_nd      in   1          in_data/in_m valid this cycle (at most 1 sample/cycle, gaps allowed)
//  in_m       in   M_WDTH     tag accompanying in_data
//  in_first   in   1          qualifies in_nd: sample is index 0 of a frame (dit 'first')
//  out_data   out  X_WDTH*2   sample in natural order
//  out_nd     out  1          out_data/out_m valid
//  out_m      out  M_WDTH     tag stored with that sample
//  out_first  out  1          with out_nd: natural index 0 of a frame
//  error      out  1          sticky misalignment/overflow flag, cleared only by rst
// BEHAVIOUR
//  Reset: out_nd=0, out_first=0, error=0, out_data=0, out_m=0; write count=0, wbank=0;
//   both banks empty; reader IDLE; unsynced=1. RAM contents are not reset.
//  Write side: sample k of a frame (k=0..N-1, counted on in_nd) goes to address
//   {wbank, bitrev(k)}, stored as {in_m, in_data}.
//  Sync: while unsynced, in_nd samples are dropped until the first in_nd&in_first, which
//   is taken as k=0.
//  Misalignment: in_nd&in_first with count!=0 -> error<=1, the partial frame is discarded,
//   and this sample is taken as k=0 of a new frame in the same bank.
//  Frame end: in the cycle k=N-1 is written, the bank is marked full, wbank toggles, and
//   count wraps to 0.
//  Reader FSM: IDLE -> READ when a full bank exists (checked the cycle after marking).
//   READ issues addresses {rbank, j}, j=0..N-1, one per cycle. The RAM read is registered,
//   so out_nd is high in the cycle after address j. out_first=1 for j=0.
//   After j=N-1 the bank is marked empty and rbank toggles. If the other bank is already
//   full, READ continues with j=0 and no bubble; otherwise -> IDLE.
//  Latency: k=N-1 written at cycle t -> first out_nd (j=0) at t+2. Throughput is 1
//   sample/cycle sustained, so back-to-back frames stream gap-free.
//  Overflow: a frame ending while the target bank is still full (unreachable at <=1/cycle
//   input; checked anyway) -> error<=1, and the completing frame is dropped (bank not
//   re-marked); output is never corrupted.
//  Simultaneous: a bank going full and the other going empty in the same cycle is legal.
//   Write and read never address the same bank.
//  rst mid-frame: everything returns to reset state at once; out_nd drops the next cycle
//   and no partial frame is emitted afterwards.
//  Widths: no arithmetic on data; counters are NLOG2 bits and wrap naturally; bitrev
//   reverses NLOG2 bits.
// STRUCTURE
//  Shared header/package: bitrev function (NLOG2-bit), the X_WDTH/M_WDTH/N/NLOG2 defaults,
//   and the reader state encodings (IDLE, READ).
//  Sub-module: fft_reorder_ram, a simple dual-port RAM of depth 2*N and width
//   X_WDTH*2+M_WDTH, with 1 write port, 1 registered read port and no reset.
//  Top holds the write counter, bank-full flags, reader FSM and error logic (~200 lines).
// TESTING
//  1. N=16, one frame, in_data=bitrev(k), in_m=k, in_first on k=0, in_nd every cycle
//     -> out_data = 0..15 in order; out_m = bitrev(j); out_first only with out 0;
//     first out_nd 2 cycles after the last input.
//  2. Three back-to-back frames, no gaps -> 48 consecutive out_nd cycles, no bubble,
//     out_first at 0/16/32, error=0.
//  3. Random in_nd gaps (50% duty) -> output content identical to test 1 per frame;
//     each frame is emitted as a contiguous 16-cycle burst.
//  4. 5 samples with in_first low after reset -> dropped, no out_nd. Then a valid frame
//     -> emitted correctly, error=0.
//  5. in_first reasserted at k=7 -> error=1 (sticky), the first 7 samples never appear,
//     and the new 16-sample frame is emitted correctly.
//  6. rst pulsed for 1 cycle while k=9 is being written and the reader is mid-burst
//     -> out_nd=0 and error=0 from the next cycle; the next clean frame is output intact.

Source files
------------

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared definitions for the FFT bit-reversed-to-natural-order reorder stage:
// default sizes, reader state encoding and a bit-reverse helper.
package fft_bitrev_reorder_pkg;

    localparam int N_DEF      = 16;
    localparam int NLOG2_DEF  = 4;
    localparam int X_WDTH_DEF = 16;
    localparam int M_WDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

    // Reverse the NLOG2_DEF-bit index (bit-reversed FFT order <-> natural order).
    function automatic logic [NLOG2_DEF-1:0] bitrev(input logic [NLOG2_DEF-1:0] v);
        logic [NLOG2_DEF-1:0] r;
        for (int i = 0; i < NLOG2_DEF; i++) begin
            r[i] = v[NLOG2_DEF-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset
// on contents or on the read register.
module fft_reorder_ram
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int AWIDTH = NLOG2_DEF + 1,
    parameter int DWIDTH = 2 * X_WDTH_DEF + M_WDTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rdata_reg;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port (maps onto block RAM output register).
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: accepts an FFT output stream in bit-reversed order
// and re-emits each N-point frame in natural order, carrying tag and frame-start.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int NLOG2  = NLOG2_DEF,
    parameter int X_WDTH = X_WDTH_DEF,
    parameter int M_WDTH = M_WDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [X_WDTH*2-1:0]   in_data,
    input  logic                  in_nd,
    input  logic [M_WDTH-1:0]     in_m,
    input  logic                  in_first,
    output logic [X_WDTH*2-1:0]   out_data,
    output logic                  out_nd,
    output logic [M_WDTH-1:0]     out_m,
    output logic                  out_first,
    output logic                  error
);

    localparam int DWIDTH = X_WDTH * 2 + M_WDTH;
    localparam logic [NLOG2-1:0] LAST_IDX = NLOG2'(N - 1);

    // Write-side state
    logic [NLOG2-1:0] wcount_reg, wcount_next;
    logic             wbank_reg, wbank_next;
    logic             unsynced_reg, unsynced_next;
    logic             error_reg, error_next;
    logic [1:0]       full_reg, full_next;
    logic [1:0]       full_set, full_clr;

    // Read-side state
    rd_state_t        state_reg, state_next;
    logic             rbank_reg, rbank_next;
    logic [NLOG2-1:0] rcount_reg, rcount_next;
    logic             rd_en, rd_first;
    logic             out_nd_reg, out_first_reg;

    // Write-path decode
    logic             take;
    logic             last;
    logic             misalign;
    logic             wr_en;
    logic [NLOG2-1:0] k;
    logic [NLOG2-1:0] k_rev;
    logic [DWIDTH-1:0] rd_word;

    // A sample is accepted once synced; a frame-start always (re)syncs.
    assign take     = in_nd & (~unsynced_reg | in_first);
    assign k        = in_first ? '0 : wcount_reg;
    assign last     = take & (k == LAST_IDX);
    assign misalign = in_nd & in_first & ~unsynced_reg & (wcount_reg != '0);
    // Never write into a bank still waiting to be read, so output stays intact.
    assign wr_en    = take & ~full_reg[wbank_reg];

    generate
        for (genvar gi = 0; gi < NLOG2; gi++) begin : g_bitrev
            assign k_rev[gi] = k[NLOG2-1-gi];
        end
    endgenerate

    // Write counter, bank select, sync tracking, full marking and error flag.
    always_comb begin
        wcount_next   = wcount_reg;
        wbank_next    = wbank_reg;
        unsynced_next = unsynced_reg;
        error_next    = error_reg;
        full_set      = 2'b00;
        if (take) begin
            unsynced_next = 1'b0;
            if (last) begin
                wcount_next = '0;
                if (full_reg[wbank_reg]) begin
                    // Overflow: drop the completing frame, keep the bank as is.
                    error_next = 1'b1;
                end else begin
                    full_set[wbank_reg] = 1'b1;
                    wbank_next          = ~wbank_reg;
                end
            end else begin
                wcount_next = k + 1'b1;
            end
        end
        if (misalign) begin
            error_next = 1'b1;
        end
    end

    // Reader FSM: stream one full bank in natural order, chaining banks gap-free.
    always_comb begin
        state_next  = state_reg;
        rbank_next  = rbank_reg;
        rcount_next = rcount_reg;
        rd_en       = 1'b0;
        rd_first    = 1'b0;
        full_clr    = 2'b00;
        case (state_reg)
            ST_IDLE: begin
                // rcount_reg is always 0 here; issue j=0 straight away.
                if (full_reg[rbank_reg]) begin
                    rd_en       = 1'b1;
                    rd_first    = 1'b1;
                    rcount_next = rcount_reg + 1'b1;
                    state_next  = ST_READ;
                end
            end
            ST_READ: begin
                rd_en       = 1'b1;
                rd_first    = (rcount_reg == '0);
                rcount_next = rcount_reg + 1'b1;
                if (rcount_reg == LAST_IDX) begin
                    full_clr[rbank_reg] = 1'b1;
                    rbank_next          = ~rbank_reg;
                    if (!full_reg[~rbank_reg]) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign full_next = (full_reg & ~full_clr) | full_set;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcount_reg    <= '0;
            wbank_reg     <= 1'b0;
            unsynced_reg  <= 1'b1;
            error_reg     <= 1'b0;
            full_reg      <= 2'b00;
            state_reg     <= ST_IDLE;
            rbank_reg     <= 1'b0;
            rcount_reg    <= '0;
            out_nd_reg    <= 1'b0;
            out_first_reg <= 1'b0;
        end else begin
            wcount_reg    <= wcount_next;
            wbank_reg     <= wbank_next;
            unsynced_reg  <= unsynced_next;
            error_reg     <= error_next;
            full_reg      <= full_next;
            state_reg     <= state_next;
            rbank_reg     <= rbank_next;
            rcount_reg    <= rcount_next;
            out_nd_reg    <= rd_en;
            out_first_reg <= rd_en & rd_first;
        end
    end

    fft_reorder_ram #(
        .AWIDTH (NLOG2 + 1),
        .DWIDTH (DWIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wbank_reg, k_rev}),
        .wdata ({in_m, in_data}),
        .re    (rd_en),
        .raddr ({rbank_reg, rcount_reg}),
        .rdata (rd_word)
    );

    // The RAM read register is not reset, so data/tag are forced to 0 when not valid.
    assign out_nd    = out_nd_reg;
    assign out_first = out_first_reg;
    assign out_data  = out_nd_reg ? rd_word[X_WDTH*2-1:0] : '0;
    assign out_m     = out_nd_reg ? rd_word[DWIDTH-1:X_WDTH*2] : '0;
    assign error     = error_reg;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: behavioural frame model with a
// per-cycle output scoreboard plus directed scenario checks.
module tb_fft_bitrev_reorder;
    import fft_bitrev_reorder_pkg::*;

    localparam int N = N_DEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_nd;
    logic [7:0]  in_m;
    logic        in_first;
    logic [31:0] out_data;
    logic        out_nd;
    logic [7:0]  out_m;
    logic        out_first;
    logic        error;

    fft_bitrev_reorder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_nd     (in_nd),
        .in_m      (in_m),
        .in_first  (in_first),
        .out_data  (out_data),
        .out_nd    (out_nd),
        .out_m     (out_m),
        .out_first (out_first),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        first;
        logic [7:0]  m;
        logic [31:0] d;
    } ev_t;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  chk_en   = 0;
    int  last_in_cyc = 0;

    ev_t expq[$];
    ev_t seen[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures < 40) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: gather each frame in arrival order, then schedule its
    // natural-order readout as a 16-cycle burst no earlier than 2 cycles after
    // the last sample and never overlapping the previous burst.
    bit          m_unsynced = 1;
    int          m_k = 0;
    bit          m_err = 0;
    int          m_next_free = 0;
    logic [31:0] fbuf [N];
    logic [7:0]  mbuf [N];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_unsynced  = 1;
            m_k         = 0;
            m_err       = 0;
            m_next_free = 0;
            expq.delete();
        end else if (in_nd) begin
            if (in_first) begin
                if (!m_unsynced && m_k != 0) m_err = 1;
                m_unsynced = 0;
                m_k        = 0;
            end
            if (!m_unsynced) begin
                fbuf[m_k] = in_data;
                mbuf[m_k] = in_m;
                m_k++;
                if (m_k == N) begin
                    int start;
                    m_k   = 0;
                    start = (cyc + 1 > m_next_free) ? cyc + 1 : m_next_free;
                    for (int j = 0; j < N; j++) begin
                        ev_t e;
                        int  src;
                        src     = int'(bitrev(NLOG2_DEF'(j)));
                        e.cyc   = start + j;
                        e.first = (j == 0);
                        e.m     = mbuf[src];
                        e.d     = fbuf[src];
                        expq.push_back(e);
                    end
                    m_next_free = start + N;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model schedule.
    always @(negedge clk) begin
        if (chk_en) begin
            if (out_nd) begin
                ev_t s;
                s.cyc = cyc; s.first = out_first; s.m = out_m; s.d = out_data;
                seen.push_back(s);
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                check("out_nd", out_nd, 1);
                check("out_first", out_first, expq[0].first);
                check("out_m", out_m, expq[0].m);
                check("out_data", out_data, expq[0].d);
                void'(expq.pop_front());
            end else begin
                check("out_nd_idle", out_nd, 0);
            end
            check("error", error, m_err);
        end
    end

    task automatic drive(input logic nd, input logic first, input logic [31:0] d, input logic [7:0] m);
        in_nd = nd; in_first = first; in_data = d; in_m = m;
        @(posedge clk); #1;
        in_nd = 0; in_first = 0;
    endtask

    task automatic send_frame(input bit br_data, input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) drive(0, 0, $urandom, 8'($urandom));
            end
            if (k == N - 1) last_in_cyc = cyc;
            if (br_data) drive(1, k == 0, 32'(bitrev(NLOG2_DEF'(k))), 8'(k));
            else         drive(1, k == 0, $urandom, 8'($urandom));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_in_time", n < 300, 1);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic check_natural(input string name, input int base);
        for (int j = 0; j < N; j++) begin
            check(name, seen[base + j].d, j);
            check(name, seen[base + j].cyc, seen[base].cyc + j);
        end
    endtask

    initial begin
        in_nd = 0; in_first = 0; in_data = 0; in_m = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        @(negedge clk);
        check("rst_out_nd", out_nd, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_m", out_m, 0);
        check("rst_error", error, 0);
        @(posedge clk); #1;

        // 1: single frame with bit-reversed data
        seen.delete();
        send_frame(1, 0);
        wait_drain();
        check("t1_count", seen.size(), 16);
        if (seen.size() == 16) begin
            check("t1_latency", seen[0].cyc, last_in_cyc + 2);
            check("t1_first0", seen[0].first, 1);
            check("t1_first1", seen[1].first, 0);
            check("t1_m1", seen[1].m, 8);
            check("t1_m3", seen[3].m, 12);
            check("t1_m15", seen[15].m, 15);
            check("t1_d15", seen[15].d, 15);
            check_natural("t1_nat", 0);
        end

        // 2: three back-to-back frames, gap-free output
        seen.delete();
        for (int f = 0; f < 3; f++) send_frame(f == 1, 0);
        wait_drain();
        check("t2_count", seen.size(), 48);
        if (seen.size() == 48) begin
            check("t2_contig", seen[47].cyc, seen[0].cyc + 47);
            check("t2_first16", seen[16].first, 1);
            check("t2_first32", seen[32].first, 1);
            check("t2_first17", seen[17].first, 0);
        end
        check("t2_error", error, 0);

        // 3: random input gaps, each frame still a contiguous burst
        seen.delete();
        for (int f = 0; f < 3; f++) send_frame(1, 1);
        wait_drain();
        check("t3_count", seen.size(), 48);
        if (seen.size() == 48) begin
            for (int f = 0; f < 3; f++) check_natural("t3_nat", f * 16);
        end

        // 4: unsynced samples after reset are dropped
        do_reset();
        seen.delete();
        for (int k = 0; k < 5; k++) drive(1, 0, $urandom, 8'($urandom));
        repeat (10) @(posedge clk);
        #1;
        check("t4_dropped", seen.size(), 0);
        send_frame(1, 0);
        wait_drain();
        check("t4_count", seen.size(), 16);
        if (seen.size() == 16) check_natural("t4_nat", 0);
        check("t4_error", error, 0);

        // 5: frame restart at k=7
        seen.delete();
        for (int k = 0; k < 7; k++) drive(1, k == 0, 32'hDEAD_0000 + 32'(k), 8'hEE);
        send_frame(1, 0);
        wait_drain();
        check("t5_error", error, 1);
        check("t5_count", seen.size(), 16);
        if (seen.size() == 16) check_natural("t5_nat", 0);

        // 6: reset while k=9 is written and the reader is mid-burst
        send_frame(1, 0);
        for (int k = 0; k < 9; k++) drive(1, k == 0, $urandom, 8'($urandom));
        rst = 1;
        drive(1, 0, $urandom, 8'($urandom));
        rst = 0;
        check("t6_nd_after_rst", out_nd, 0);
        check("t6_err_after_rst", error, 0);
        seen.delete();
        repeat (25) @(posedge clk);
        #1;
        check("t6_no_partial", seen.size(), 0);
        send_frame(1, 1);
        wait_drain();
        check("t6_count", seen.size(), 16);
        if (seen.size() == 16) check_natural("t6_nat", 0);
        check("t6_error", error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
